game_sequencer: RTL and testbench

Central controller for the obstacle-dodging game. It runs the game state machine, generates the obstacle-advance strobe, and moves the hero between three lanes on keypad events. It spawns pseudo-random obstacles that scroll across three 7-segment digits, and detects collisions and win/lose. It sits between the keypad decoder (`key`, `keypad_pressed`) and the display drivers (`heroe`, `display_obs`); `presente` and `W_or_L` are exported for the status LEDs and debug capture.

---
 rtl/game_sequencer.sv | 175 +++++++++++++++++
 tb/tb_game_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Obstacle-dodging game controller: game FSM, obstacle-advance timer, hero lane,
// LFSR obstacle spawner, collision and win/lose detection.
//
// state   | meaning
// IDLE    | board cleared, waiting for start (key 5)
// PLAY    | timer running, obstacles scroll, hero moves
// WIN     | SCORE_WIN obstacles passed, displays frozen
// LOSE    | obstacle hit the hero, displays frozen
// PAUSE   | timer and hero frozen until key 10
module game_sequencer #(
  parameter int TICK_DIV  = 6_750_000,
  parameter int SCORE_WIN = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  key,
  input  logic        keypad_pressed,
  output logic [2:0]  presente,
  output logic [1:0]  W_or_L,
  output logic [6:0]  heroe,
  output logic [20:0] display_obs,
  output logic        clk_obstaculos,
  output logic [7:0]  score
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_WIN   = 3'd2,
    S_LOSE  = 3'd3,
    S_PAUSE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        obs_v_q, obs_v_d;
  logic [2:0][1:0]   obs_l_q, obs_l_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [7:0]        score_q, score_d;
  logic              strobe_q, strobe_d;

  logic k_start, k_pause, k_up, k_down;
  logic hit, spawn_v, go_idle;

  assign k_start = keypad_pressed && (key == 5'd5);
  assign k_pause = keypad_pressed && (key == 5'd10);
  assign k_up    = keypad_pressed && (key == 5'd2);
  assign k_down  = keypad_pressed && (key == 5'd8);

  assign hit     = (state_q == S_PLAY) && obs_v_q[0] && (obs_l_q[0] == lane_q);
  assign spawn_v = lfsr_q[2] && (lfsr_q[1:0] != 2'd3);

  function automatic logic [6:0] lane_seg(input logic v, input logic [1:0] l);
    logic [6:0] s;
    s = 7'h00;
    if (v) begin
      case (l)
        2'd0:    s = 7'h01;
        2'd2:    s = 7'h08;
        default: s = 7'h40;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    lane_d   = lane_q;
    obs_v_d  = obs_v_q;
    obs_l_d  = obs_l_q;
    lfsr_d   = lfsr_q;
    score_d  = score_q;
    strobe_d = 1'b0;
    go_idle  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (k_start) begin
          state_d = S_PLAY;
          tick_d  = TICK_LAST;
        end
      end
      S_PLAY: begin
        if (hit) begin
          state_d = S_LOSE;
        end else if (k_start) begin
          go_idle = 1'b1;
        end else if (k_pause) begin
          state_d = S_PAUSE;
        end else begin
          if (k_up && lane_q != 2'd0) begin
            lane_d = lane_q - 2'd1;
          end else if (k_down && lane_q != 2'd2) begin
            lane_d = lane_q + 2'd1;
          end
          // Down-counter reaching zero is the advance instant.
          if (tick_q == '0) begin
            tick_d  = TICK_LAST;
            obs_v_d = {spawn_v, obs_v_q[2:1]};
            obs_l_d = {lfsr_q[1:0], obs_l_q[2], obs_l_q[1]};
            lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (obs_v_q[0]) begin
              score_d = score_q + 8'd1;
            end
            if (obs_v_q[0] && (score_q + 8'd1 == 8'(SCORE_WIN))) begin
              state_d = S_WIN;
            end else begin
              strobe_d = 1'b1;
            end
          end else begin
            tick_d = tick_q - TW'(1);
          end
        end
      end
      S_PAUSE: begin
        if (k_start) begin
          go_idle = 1'b1;
        end else if (k_pause) begin
          state_d = S_PLAY;
        end
      end
      S_WIN, S_LOSE: begin
        if (k_start) begin
          go_idle = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d = S_IDLE;
      obs_v_d = '0;
      score_d = '0;
      lane_d  = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      lane_q   <= 2'd1;
      obs_v_q  <= '0;
      obs_l_q  <= '0;
      lfsr_q   <= 8'hA5;
      score_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      lane_q   <= lane_d;
      obs_v_q  <= obs_v_d;
      obs_l_q  <= obs_l_d;
      lfsr_q   <= lfsr_d;
      score_q  <= score_d;
      strobe_q <= strobe_d;
    end
  end

  assign presente       = state_q;
  assign W_or_L         = (state_q == S_WIN)  ? 2'b01 :
                          (state_q == S_LOSE) ? 2'b10 : 2'b00;
  assign heroe          = lane_seg(1'b1, lane_q);
  assign display_obs    = {lane_seg(obs_v_q[2], obs_l_q[2]),
                           lane_seg(obs_v_q[1], obs_l_q[1]),
                           lane_seg(obs_v_q[0], obs_l_q[0])};
  assign clk_obstaculos = strobe_q;
  assign score          = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a lane/array game model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_game_sequencer;
  localparam int TICK_DIV  = 4;
  localparam int SCORE_WIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  key = '0;
  logic        kp = 1'b0;
  logic [2:0]  presente;
  logic [1:0]  W_or_L;
  logic [6:0]  heroe;
  logic [20:0] display_obs;
  logic        clk_obstaculos;
  logic [7:0]  score;

  game_sequencer #(.TICK_DIV(TICK_DIV), .SCORE_WIN(SCORE_WIN)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .keypad_pressed(kp),
    .presente(presente), .W_or_L(W_or_L), .heroe(heroe),
    .display_obs(display_obs), .clk_obstaculos(clk_obstaculos), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  wl;
    logic [6:0]  hero;
    logic [20:0] obs;
    logic        strobe;
    logic [7:0]  score;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;
  bit   smart = 1;

  // Game model: mode 0 idle,1 play,2 win,3 lose,4 pause; obstacle lane -1 = empty.
  int         m_mode, m_hero, m_tick, m_score, m_wl;
  int         m_obs[3];
  logic [7:0] m_lfsr;
  bit         m_strobe;

  function automatic logic [6:0] seg7(input int lane);
    case (lane)
      0: return 7'h01;
      1: return 7'h40;
      2: return 7'h08;
      default: return 7'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_hero = 1; m_tick = 0; m_score = 0; m_wl = 0;
    m_obs[0] = -1; m_obs[1] = -1; m_obs[2] = -1;
    m_lfsr = 8'hA5; m_strobe = 0;
  endtask

  task automatic m_idle();
    m_mode = 0; m_wl = 0; m_hero = 1; m_score = 0;
    m_obs[0] = -1; m_obs[1] = -1; m_obs[2] = -1;
  endtask

  task automatic m_step(input bit p, input int k);
    bit k5, k10, k2, k8;
    k5 = p && k == 5; k10 = p && k == 10; k2 = p && k == 2; k8 = p && k == 8;
    m_strobe = 0;
    case (m_mode)
      0: if (k5) begin m_mode = 1; m_tick = 0; end
      1: begin
        if (m_obs[0] == m_hero) begin
          m_mode = 3; m_wl = 2;
        end else if (k5) begin
          m_idle();
        end else if (k10) begin
          m_mode = 4;
        end else begin
          if (k2 && m_hero > 0) m_hero--;
          if (k8 && m_hero < 2) m_hero++;
          if (m_tick == TICK_DIV - 1) begin
            m_tick = 0;
            if (m_obs[0] >= 0) m_score++;
            m_obs[0] = m_obs[1];
            m_obs[1] = m_obs[2];
            m_obs[2] = (m_lfsr[2] && m_lfsr[1:0] != 2'd3) ? int'(m_lfsr[1:0]) : -1;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            if (m_score == SCORE_WIN) begin m_mode = 2; m_wl = 1; end
            else m_strobe = 1;
          end else begin
            m_tick++;
          end
        end
      end
      4: if (k5) m_idle(); else if (k10) m_mode = 1;
      default: if (k5) m_idle();
    endcase
  endtask

  task automatic push();
    exp_t e;
    e.st = 3'(m_mode); e.wl = 2'(m_wl); e.hero = seg7(m_hero);
    e.obs = {seg7(m_obs[2]), seg7(m_obs[1]), seg7(m_obs[0])};
    e.strobe = m_strobe; e.score = 8'(m_score);
    sb.push_back(e);
  endtask

  // Called at posedge+1; after return rst_n is released and the current cycle is queued.
  task automatic do_reset(input int n);
    rst_n = 1'b0; kp = 1'b0;
    sb.delete(); m_reset(); push(); mon_en = 1;
    repeat (n) begin @(posedge clk); #1; push(); end
    rst_n = 1'b1;
  endtask

  task automatic step(input bit p, input int k);
    kp  = p;
    key = p ? 5'(k) : 5'($urandom_range(0, 31));
    m_step(p, k); push();
    @(posedge clk); #1;
    kp = 1'b0;
  endtask

  task automatic choose(output bit p, output int k);
    int r;
    bit term;
    r = $urandom_range(0, 99);
    term = (m_tick == TICK_DIV - 1);
    p = 0; k = 0;
    case (m_mode)
      1: begin
        if (!term && r < 2) begin p = 1; k = 5; end
        else if (!term && r < 4) begin p = 1; k = 10; end
        else if (smart && m_obs[1] == m_hero) begin
          p = 1;
          if (m_hero > 0 && m_hero - 1 != m_obs[0] && m_hero - 1 != m_obs[1]) k = 2;
          else k = 8;
        end else if (r < 20) begin p = 1; k = r[0] ? 2 : 8; end
        else if (r < 24) begin
          p = 1; k = $urandom_range(0, 31);
          if (k == 5 || k == 10) k = 3;
        end
      end
      4: if (r < 15) begin p = 1; k = 10; end else if (r < 17) begin p = 1; k = 5; end
      default: begin
        if (r < 25) begin p = 1; k = 5; smart = ($urandom_range(0, 7) != 0); end
        else if (r < 30) begin p = 1; k = $urandom_range(0, 31); end
      end
    endcase
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty at %0t: actual=none expected=entry", $time);
      end else begin
        e = sb.pop_front();
        check("presente", presente, e.st);
        check("W_or_L", W_or_L, e.wl);
        check("heroe", heroe, e.hero);
        check("display_obs", display_obs, e.obs);
        check("clk_obstaculos", clk_obstaculos, e.strobe);
        check("score", score, e.score);
      end
    end
  end

  initial begin
    int n, k;
    bit p;
    @(posedge clk); #1;
    do_reset(2);
    check("reset_presente", presente, 0);
    check("reset_heroe", heroe, 7'h40);

    // Start, first advance after TICK_DIV cycles, then middle obstacle hits middle hero.
    repeat (2) step(0, 0);
    step(1, 5);
    check("start_presente", presente, 1);
    repeat (3) step(0, 0);
    check("no_early_tick", clk_obstaculos, 0);
    step(0, 0);
    check("first_tick", clk_obstaculos, 1);
    check("first_spawn", display_obs[20:14], 7'h40);
    repeat (9) step(0, 0);
    check("lose_presente", presente, 3);
    check("lose_wl", W_or_L, 2);
    check("lose_score", score, 0);
    step(1, 5);
    check("idle_obs", display_obs, 0);
    check("idle_score", score, 0);

    // Lane saturation, pause freezes the timer, resume continues the count.
    step(1, 5);
    step(1, 8); step(1, 8); step(1, 8);
    check("sat_heroe", heroe, 7'h08);
    step(0, 0);
    step(1, 10);
    check("pause_presente", presente, 4);
    n = 0;
    repeat (20) begin step(0, 0); n += int'(clk_obstaculos); end
    check("pause_no_tick", n, 0);
    step(1, 10);
    check("resume_presente", presente, 1);
    repeat (3) step(0, 0);
    check("resume_no_tick", clk_obstaculos, 0);
    step(0, 0);
    check("resume_tick", clk_obstaculos, 1);
    step(1, 5);

    // Random play with dodging; a mid-run reset restarts the spawn sequence.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset(3);
      choose(p, k);
      step(p, k);
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
